// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: drives program-memory address, presents fetched
// instructions to decode over valid/ready, and handles jump/call/return/halt.
module fetch_sequencer #(
  parameter int unsigned PC_WIDTH    = 8,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned STACK_DEPTH = 4,
  parameter int unsigned RESET_PC    = 0
) (
  input  logic                               clk,
  input  logic                               res,
  output logic [PC_WIDTH-1:0]                mem_pc,
  input  logic [DATA_WIDTH-1:0]              mem_ir,
  output logic [DATA_WIDTH-1:0]              ir_out,
  output logic [PC_WIDTH-1:0]                ir_pc,
  output logic                               ir_valid,
  input  logic                               ir_ready,
  input  logic                               redir_valid,
  input  logic                               redir_call,
  input  logic                               redir_ret,
  input  logic [PC_WIDTH-1:0]                redir_pc,
  input  logic                               halt,
  input  logic                               resume,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_depth,
  output logic                               stack_err,
  output logic [15:0]                        fetch_cnt
);

  localparam int unsigned DW = $clog2(STACK_DEPTH + 1);
  localparam int unsigned AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALT
  } state_t;

  state_t                state_q;
  logic [PC_WIDTH-1:0]   ir_pc_q;
  logic                  ir_valid_q;
  logic [DW-1:0]         depth_q;
  logic                  err_q;
  logic [15:0]           cnt_q;
  logic [PC_WIDTH-1:0]   stack_q [2**AW];

  logic                  xfer;
  logic [PC_WIDTH-1:0]   seq_pc;
  logic [PC_WIDTH-1:0]   stack_top;
  logic [PC_WIDTH-1:0]   next_pc_d;
  logic [DW-1:0]         depth_d;
  logic                  err_d;
  logic                  push;
  logic                  pop;

  always_comb begin
    xfer      = ir_valid_q & ir_ready;
    seq_pc    = ir_pc_q + PC_WIDTH'(1);
    stack_top = stack_q[AW'(depth_q - DW'(1))];
    next_pc_d = seq_pc;
    push      = 1'b0;
    pop       = 1'b0;
    err_d     = err_q;
    if (redir_valid) begin
      if (redir_call) begin
        next_pc_d = redir_pc;
        if (depth_q == DW'(STACK_DEPTH)) err_d = 1'b1;
        else                             push  = 1'b1;
        if (redir_ret) err_d = 1'b1;
      end else if (redir_ret) begin
        if (depth_q == '0) begin
          err_d = 1'b1;
        end else begin
          pop       = 1'b1;
          next_pc_d = stack_top;
        end
      end else begin
        next_pc_d = redir_pc;
      end
    end
    depth_d = depth_q;
    if (push)     depth_d = depth_q + DW'(1);
    else if (pop) depth_d = depth_q - DW'(1);
    // In HALT ir_pc_q already holds the resume address, so one mux covers every state.
    mem_pc = xfer ? next_pc_d : ir_pc_q;
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q    <= S_IDLE;
      ir_pc_q    <= PC_WIDTH'(RESET_PC);
      ir_valid_q <= 1'b0;
      depth_q    <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q    <= S_RUN;
          ir_valid_q <= 1'b1;
        end
        S_RUN: begin
          if (xfer) begin
            ir_pc_q <= next_pc_d;
            depth_q <= depth_d;
            err_q   <= err_d;
            cnt_q   <= cnt_q + 16'd1;
            if (halt) begin
              state_q    <= S_HALT;
              ir_valid_q <= 1'b0;
            end
          end
        end
        S_HALT: begin
          if (resume) begin
            state_q    <= S_RUN;
            ir_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          ir_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Stack contents need no reset: occupancy alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (xfer && push) stack_q[AW'(depth_q)] <= seq_pc;
  end

  assign ir_out      = mem_ir;
  assign ir_pc       = ir_pc_q;
  assign ir_valid    = ir_valid_q;
  assign stack_depth = depth_q;
  assign stack_err   = err_q;
  assign fetch_cnt   = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios then randomized traffic,
// checked against a queue-based reference model and a transfer scoreboard.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        res = 1'b0;
  logic [7:0]  mem_pc;
  logic [15:0] mem_ir;
  logic [15:0] ir_out;
  logic [7:0]  ir_pc;
  logic        ir_valid;
  logic        ir_ready = 1'b0;
  logic        redir_valid = 1'b0;
  logic        redir_call = 1'b0;
  logic        redir_ret = 1'b0;
  logic [7:0]  redir_pc = '0;
  logic        halt = 1'b0;
  logic        resume = 1'b0;
  logic [2:0]  stack_depth;
  logic        stack_err;
  logic [15:0] fetch_cnt;

  always #5 clk = ~clk;

  fetch_sequencer #(
    .PC_WIDTH(8), .DATA_WIDTH(16), .STACK_DEPTH(4), .RESET_PC(0)
  ) dut (
    .clk(clk), .res(res), .mem_pc(mem_pc), .mem_ir(mem_ir),
    .ir_out(ir_out), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .redir_valid(redir_valid), .redir_call(redir_call), .redir_ret(redir_ret),
    .redir_pc(redir_pc), .halt(halt), .resume(resume),
    .stack_depth(stack_depth), .stack_err(stack_err), .fetch_cnt(fetch_cnt)
  );

  logic [15:0] mem [256];
  always @(posedge clk) mem_ir <= mem[mem_pc];

  typedef struct {
    logic [7:0]  pc;
    logic [15:0] ir;
  } exp_t;
  exp_t exp_q[$];

  bit          m_idle, m_valid, m_halt, m_err;
  logic [7:0]  m_pc;
  logic [7:0]  m_stk[$];
  logic [15:0] m_cnt;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_idle = 1; m_valid = 0; m_halt = 0; m_err = 0;
    m_pc = 8'h00; m_cnt = 16'h0;
    m_stk.delete();
    exp_q.delete();
  endtask

  // Called at a falling edge: drive one cycle of inputs, predict, check.
  task automatic cycle(input bit rdy, input bit rv, input bit rc, input bit rr,
                       input logic [7:0] rpc, input bit hlt, input bit rs);
    logic [7:0] seq;
    logic [7:0] tgt;
    bit         xf;
    ir_ready = rdy; redir_valid = rv; redir_call = rc; redir_ret = rr;
    redir_pc = rpc; halt = hlt; resume = rs;
    xf  = m_valid && rdy;
    seq = m_pc + 8'd1;
    tgt = seq;
    if (xf) begin
      exp_q.push_back('{m_pc, mem[m_pc]});
      if (rv && rc) begin
        tgt = rpc;
        if (m_stk.size() < 4) m_stk.push_back(seq);
        else                  m_err = 1;
        if (rr) m_err = 1;
      end else if (rv && rr) begin
        if (m_stk.size() > 0) tgt = m_stk.pop_back();
        else                  m_err = 1;
      end else if (rv) begin
        tgt = rpc;
      end
    end
    #1;
    chk("mem_pc", mem_pc, xf ? tgt : m_pc);
    if (m_idle) begin
      m_idle = 0; m_valid = 1;
    end else if (m_halt) begin
      if (rs) begin m_halt = 0; m_valid = 1; end
    end else if (xf) begin
      m_pc  = tgt;
      m_cnt = m_cnt + 16'd1;
      if (hlt) begin m_halt = 1; m_valid = 0; end
    end
    @(negedge clk);
    chk("ir_valid", ir_valid, m_valid);
    if (m_valid) begin
      chk("ir_pc", ir_pc, m_pc);
      chk("ir_out", ir_out, mem[m_pc]);
    end
    chk("stack_depth", stack_depth, m_stk.size());
    chk("stack_err", stack_err, m_err);
    chk("fetch_cnt", fetch_cnt, m_cnt);
  endtask

  task automatic pulse_reset();
    res = 1'b1;
    #1;
    chk("rst_valid", ir_valid, 0);
    chk("rst_depth", stack_depth, 0);
    chk("rst_cnt", fetch_cnt, 0);
    chk("rst_err", stack_err, 0);
    chk("rst_mem_pc", mem_pc, 0);
    model_reset();
    @(negedge clk);
    res = 1'b0;
  endtask

  task automatic seqc(input bit hlt);
    cycle(1, 0, 0, 0, 8'h00, hlt, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (ir_valid === 1'b1 && ir_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL sb_unexpected: got transfer pc 0x%0h, expected none", ir_pc);
        end else begin
          e = exp_q.pop_front();
          chk("sb_pc", ir_pc, e.pc);
          chk("sb_ir", ir_out, e.ir);
        end
      end
    end
  end

  initial begin : stim
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    model_reset();
    #1 res = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_valid", ir_valid, 0);
    chk("reset_pc", ir_pc, 0);
    res = 1'b0;

    seqc(0);                                        // IDLE -> RUN at pc 0
    repeat (3) seqc(0);
    chk("fetch_cnt_3", fetch_cnt, 3);
    repeat (2) seqc(0);                             // pc 5
    repeat (3) cycle(0, 1, 0, 0, 8'h77, 1, 0);      // stall, redirect and halt ignored
    seqc(0);                                        // pc 6
    cycle(1, 1, 0, 0, 8'h0A, 0, 0);
    cycle(1, 1, 0, 0, 8'h20, 0, 0);
    cycle(1, 1, 1, 0, 8'h40, 0, 0);
    cycle(1, 1, 1, 0, 8'h50, 0, 0);
    cycle(1, 1, 1, 0, 8'h60, 0, 0);
    cycle(1, 1, 1, 0, 8'h70, 0, 0);
    cycle(1, 1, 1, 0, 8'h80, 0, 0);                 // overflow
    chk("ovf_depth", stack_depth, 4);
    chk("ovf_err", stack_err, 1);
    repeat (4) cycle(1, 1, 0, 1, 8'h00, 0, 0);
    chk("ret_lifo_last", ir_pc, 8'h21);
    cycle(1, 1, 0, 1, 8'h00, 0, 0);                 // underflow
    chk("underflow_pc", ir_pc, 8'h22);
    cycle(1, 0, 1, 1, 8'h99, 0, 0);                 // call/ret without redir_valid
    cycle(1, 1, 0, 0, 8'h08, 0, 0);
    seqc(1);                                        // halt at 8
    repeat (3) cycle(1, 0, 0, 0, 8'h00, 0, 0);
    cycle(1, 0, 0, 0, 8'h00, 0, 1);
    chk("resume_pc", ir_pc, 8'h09);
    cycle(1, 1, 0, 0, 8'h30, 1, 0);                 // halt with jump
    cycle(1, 0, 0, 0, 8'h00, 0, 1);
    chk("resume_jump_pc", ir_pc, 8'h30);
    cycle(1, 1, 0, 0, 8'hFF, 0, 0);
    seqc(0);
    chk("wrap_pc", ir_pc, 8'h00);
    cycle(1, 1, 0, 0, 8'hFF, 0, 0);
    cycle(1, 1, 1, 0, 8'h10, 0, 0);                 // call at 0xFF pushes 0x00
    cycle(1, 1, 0, 1, 8'h00, 0, 0);
    chk("wrap_ret_pc", ir_pc, 8'h00);
    cycle(1, 1, 1, 1, 8'h33, 0, 0);                 // call+ret conflict
    cycle(0, 0, 0, 0, 8'h00, 0, 0);
    pulse_reset();

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) pulse_reset();
      else cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                 8'($urandom), $urandom_range(0, 19) == 0,
                 $urandom_range(0, 2) == 0);
    end
    cycle(0, 0, 0, 0, 8'h00, 0, 0);
    chk("sb_drain", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction fetch sequencer for the Jac1-8 core. It drives the address of the synchronous-read program memory and presents each fetched instruction, together with its address, to decode over a valid/ready handshake. It handles jump, call and return redirects, using an internal return-address stack. It also handles halt and resume. It sits between the program memory (8-bit address in, 16-bit instruction out one clock later) and the decode/execute stage.

## Interface
- PC_WIDTH, 8: program address width
- DATA_WIDTH, 16: instruction width
- STACK_DEPTH, 4: return-stack entries (≥1)
- RESET_PC, 0: first fetch address after reset
- clk  in  1  clock, all state updates on rising edge
- res  in  1  reset, asynchronous, active-high
- mem_pc  out  PC_WIDTH  address to program memory (combinational from state)
- mem_ir  in  DATA_WIDTH  program memory data; equals M[mem_pc sampled at previous edge]
- ir_out  out  DATA_WIDTH  presented instruction (= mem_ir)
- ir_pc  out  PC_WIDTH  address of ir_out
- ir_valid  out  1  ir_out/ir_pc valid
- ir_ready  in  1  decode accepts; transfer = ir_valid & ir_ready
- redir_valid  in  1  redirect for the transferred instruction
- redir_call  in  1  redirect is a call (push return address)
- redir_ret  in  1  redirect is a return (pop target)
- redir_pc  in  PC_WIDTH  jump/call target
- halt  in  1  transferred instruction is a halt
- resume  in  1  leave HALT
- stack_depth  out  clog2(STACK_DEPTH+1)  current stack occupancy
- stack_err  out  1  sticky overflow/underflow/conflict flag
- fetch_cnt  out  16  transfers since reset, wraps at 2^16

## Operation
- Reset values: state IDLE, ir_pc=RESET_PC, ir_valid=0, stack_depth=0, stack_err=0, fetch_cnt=0. mem_pc=RESET_PC.
- mem_pc always equals the next-cycle value of ir_pc, so ir_out = M[ir_pc] whenever ir_valid=1. No internal instruction register.
- States:
  - IDLE: at the first edge after res deasserts, go to RUN, with ir_pc=RESET_PC and ir_valid=1.
  - RUN: ir_valid=1. Without a transfer, ir_pc holds, mem_pc=ir_pc, and ir_out stays stable.
  - HALT: ir_valid=0. mem_pc=resume_pc.
- redir_* and halt are sampled only on transfer cycles. Otherwise they are ignored.
- Next-address selection on a transfer, first match wins:
  - redir_valid & redir_call: push ir_pc+1, target = redir_pc.
  - redir_valid & redir_ret: pop, target = popped value.
  - redir_valid: target = redir_pc.
  - else: target = ir_pc+1.
- Call with the stack full: push dropped, jump still taken, stack_err=1.
- Return with the stack empty: target = ir_pc+1, depth stays 0, stack_err=1.
- redir_call & redir_ret together: treated as a call, stack_err=1.
- Call/ret with redir_valid=0: ignored, no error.
- Halt on a transfer: the computed target is stored as resume_pc, state goes to HALT, and ir_valid=0 next cycle. The stack is updated normally.
- HALT & resume: mem_pc=resume_pc, and at the next edge state goes to RUN with ir_pc=resume_pc and ir_valid=1.
- All PC arithmetic is modulo 2^PC_WIDTH: 0xFF+1=0x00.
- fetch_cnt increments on every transfer.
- stack_err clears only on reset.

## Timing
- Latency: ir_valid rises 1 cycle after reset release. Redirect or sequential target is presented in the cycle after the transfer, with zero bubbles, so throughput is 1 instruction/cycle.
- mem_pc is combinational from state plus the transfer and redirect inputs; there is a single path through the next-address mux.
- Resume: ir_valid rises 1 cycle after resume is sampled high in HALT.
- res assertion at any time forces all outputs to their reset values immediately (asynchronous), including mid-stall and during HALT; stack contents are discarded.

## Test plan
- Reset release, ir_ready=1, no redirects -> ir_valid=1 one cycle later with ir_pc=0 and ir_out=M[0]; then ir_pc 1,2,3 on consecutive cycles; fetch_cnt=3 after three transfers.
- ir_ready=0 for 3 cycles at ir_pc=5 -> mem_pc=5, ir_pc=5, ir_out=M[5] stable throughout; ir_pc=6 the cycle after ready returns.
- Jump at ir_pc=0x0A to 0x20 -> next cycle ir_pc=0x20, ir_out=M[0x20], no invalid cycle. Redirect asserted with ir_ready=0 -> ignored.
- Five nested calls with STACK_DEPTH=4:
  - fifth call sets stack_err=1 and stack_depth stays 4.
  - four returns go to the pushed addresses in LIFO order.
  - fifth return falls through to ir_pc+1, stack_depth=0.
- Halt at ir_pc=8 -> ir_valid=0 next cycle; resume 4 cycles later -> ir_pc=9. Halt together with jump to 0x30 -> resume presents ir_pc=0x30.
- Sequential fetch at 0xFF -> 0x00; call at 0xFF pushes 0x00. res pulsed mid-run -> ir_valid=0, stack_depth=0, fetch_cnt=0 immediately.
